// File: rtl/led_blink_reporter_if.sv
// led_blink_reporter_if: request/count inputs and LED/status outputs of the blink reporter.
interface led_blink_reporter_if #(
    parameter int CNT_LEN = 8
);
    logic [CNT_LEN-1:0] i_count;
    logic               i_start;
    logic               o_led;
    logic               o_busy;
    logic               o_done;
    modport master (output i_count, i_start, input o_led, o_busy, o_done);
    modport slave (input i_count, i_start, output o_led, o_busy, o_done);
endinterface

// File: rtl/led_blink_reporter.sv
// led_blink_reporter: blinks an LED i_count times, then holds a quiet gap and pulses o_done.
module led_blink_reporter #(
    parameter int CNT_LEN   = 8,
    parameter int ON_TICKS  = 24000000,
    parameter int OFF_TICKS = 24000000,
    parameter int GAP_TICKS = 48000000
) (
    input logic                i_clk,
    input logic                i_rst,
    led_blink_reporter_if.slave bus
);
    localparam int MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_T  = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
    localparam int TW     = $clog2(MAX_T + 1);
    // Timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TW-1:0] T_ON  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] T_OFF = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] T_GAP = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [TW-1:0]      r_timer, w_timer_nxt;
    logic [CNT_LEN-1:0] r_remain, w_remain_nxt;
    logic               r_led, r_busy, r_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_remain_nxt = r_remain;
        case (r_state)
            IDLE: if (bus.i_start) begin
                if (bus.i_count != '0) begin
                    w_state_nxt  = ON;
                    w_timer_nxt  = T_ON;
                    w_remain_nxt = bus.i_count;
                end else begin
                    w_state_nxt = GAP;
                    w_timer_nxt = T_GAP;
                end
            end
            ON: if (r_timer != '0) w_timer_nxt = r_timer - 1'b1;
            else begin
                w_state_nxt = OFF;
                w_timer_nxt = T_OFF;
            end
            OFF: if (r_timer != '0) w_timer_nxt = r_timer - 1'b1;
            else begin
                w_remain_nxt = r_remain - 1'b1;
                w_state_nxt  = (r_remain != CNT_LEN'(1)) ? ON : GAP;
                w_timer_nxt  = (r_remain != CNT_LEN'(1)) ? T_ON : T_GAP;
            end
            GAP: if (r_timer != '0) w_timer_nxt = r_timer - 1'b1;
            else w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_timer  <= '0;
            r_remain <= '0;
            r_led    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_remain <= w_remain_nxt;
            r_led    <= (w_state_nxt == ON);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (r_state == GAP) && (w_state_nxt == IDLE);
        end
    end

    assign bus.o_led  = r_led;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
endmodule

// File: doc/led_blink_reporter.md
LED_BLINK_REPORTER -- requirements
Module: led_blink_reporter

Interface
REQ-001 Parameter CNT_LEN, default 8, SHALL set the width of the press count to report.
REQ-002 Parameter ON_TICKS, default 24000000, SHALL set the LED-on cycles per blink; legal range >=1.
REQ-003 Parameter OFF_TICKS, default 24000000, SHALL set the LED-off cycles per blink; legal range >=1.
REQ-004 Parameter GAP_TICKS, default 48000000, SHALL set the trailing quiet cycles before completion; legal range >=1.
REQ-005 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 i_rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 i_count  input  CNT_LEN  SHALL be the number of blinks to emit, i.e. the debounced push-count register.
REQ-008 i_start  input  1  SHALL be a request pulse, sampled on the rising edge of i_clk.
REQ-009 o_led  output  1  SHALL be the registered LED drive, 1 = lit.
REQ-010 o_busy  output  1  SHALL be high while a report sequence is in progress.
REQ-011 o_done  output  1  SHALL be a one-cycle pulse marking the end of a sequence.

Function
REQ-012 States SHALL be IDLE, ON, OFF and GAP; one down-counter timer of width $clog2(max(ON_TICKS,OFF_TICKS,GAP_TICKS)+1) plus a CNT_LEN-bit remaining-blink counter.
REQ-013 In IDLE with i_start=1 and i_count!=0, the block SHALL latch i_count, go to ON and load the timer for ON_TICKS; o_led=1 and o_busy=1 from the next cycle.
REQ-014 In IDLE with i_start=1 and i_count==0, the block SHALL go directly to GAP with o_led held 0.
REQ-015 ON SHALL last exactly ON_TICKS cycles with o_led=1, then go to OFF.
REQ-016 OFF SHALL last exactly OFF_TICKS cycles with o_led=0, then decrement the remaining count; if the result is non-zero it SHALL go to ON, otherwise to GAP.
REQ-017 GAP SHALL last exactly GAP_TICKS cycles with o_led=0, then go to IDLE.
REQ-018 o_done SHALL be 1 for exactly the first IDLE cycle after GAP and 0 at all other times.
REQ-019 o_busy SHALL be 1 in ON, OFF and GAP, and 0 in IDLE; total busy time SHALL be N*(ON_TICKS+OFF_TICKS)+GAP_TICKS cycles for N=i_count.
REQ-020 i_start SHALL be ignored while o_busy=1; changes on i_count after latching SHALL NOT affect the sequence.
REQ-021 i_start in the o_done cycle SHALL be accepted, so back-to-back sequences are separated by exactly one IDLE cycle.
REQ-022 i_count at its maximum (all ones) SHALL produce exactly 2^CNT_LEN-1 blinks, with no counter wrap.
REQ-023 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting i_rst SHALL immediately force IDLE, o_led=0, o_busy=0, o_done=0, and clear the timer and the latched count, regardless of state.
REQ-025 While i_rst=1, i_start SHALL be ignored; the first request is accepted on the first rising edge with i_rst=0.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence with no o_done pulse.

Verification (ON_TICKS=3, OFF_TICKS=2, GAP_TICKS=4, CNT_LEN=4)
REQ-027 i_count=3, single i_start pulse -> o_led pattern 111 00 111 00 111 00, then 4 low cycles; o_busy high for 19 cycles; o_done high for 1 cycle immediately after.
REQ-028 i_count=0, i_start -> o_led stays 0; o_busy high for 4 cycles; then o_done pulses once.
REQ-029 i_count=2 with i_start, then i_start repeated and i_count changed to 9 mid-sequence -> exactly 2 blinks; o_busy high for 14 cycles; one o_done.
REQ-030 i_count=2, i_rst asserted during the second ON phase between clock edges -> o_led and o_busy go 0 without waiting for a clock edge; no o_done pulse; after release, i_count=1 request yields 1 blink and busy 9 cycles.
REQ-031 i_count=15 -> 15 blinks, o_busy high for 79 cycles, one o_done pulse.
REQ-032 i_start held high continuously with i_count=1 -> successive sequences, each 9 busy cycles, separated by exactly one IDLE cycle in which o_done=1.
